reg_file_16x16: RTL and testbench
=================================

Name: reg_file_16x16

Overview:
- 16-entry x 16-bit general-purpose register file for the CompactRISC16 datapath.
- Sits directly upstream of the 16:1 operand-select mux trees.
  - Exposes all 16 registers as a flat bus that feeds the mux trees.
  - Also provides two registered read ports with write-to-read bypass.
- Includes a sequenced clear engine that zeroes the file one register per cycle.
  - Used on soft reset and for the debug "clear regs" command.

Parameters:
- DATA_W, 16, width of each register.
- NUM_REGS, 16, number of registers; must be a power of two.
- ADDR_W, 4, register address width; equals log2(NUM_REGS).

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- wr_en  in  1  write request for this cycle.
- wr_addr  in  ADDR_W  destination register index.
- wr_data  in  DATA_W  write data.
- rd_addr_a  in  ADDR_W  read port A index.
- rd_addr_b  in  ADDR_W  read port B index.
- rd_data_a  out  DATA_W  registered read data, port A.
- rd_data_b  out  DATA_W  registered read data, port B.
- regs_flat  out  NUM_REGS*DATA_W  all registers; reg i occupies bits [i*DATA_W +: DATA_W]. Feeds the 16:1 mux trees.
- clr_req  in  1  single-cycle pulse that starts the clear sequence.
- busy  out  1  high while the clear sequence runs.
- wr_drop  out  1  registered; high for one cycle when a write was discarded.

Behaviour:
- Reset (reset_n==0 sampled at a clk edge):
  - All registers become 0; rd_data_a, rd_data_b, busy and wr_drop become 0.
  - FSM goes to IDLE; clear index goes to 0.
  - Reset overrides every other input in the same cycle, including reset asserted mid-clear.
- Write, IDLE state: wr_en=1 updates reg[wr_addr] <= wr_data at the edge.
  - The new value is visible on regs_flat the following cycle.
- Read latency is 1 cycle: rd_data_x <= reg[rd_addr_x] at each edge, in both states.
- Bypass (IDLE only): if wr_en=1 and wr_addr==rd_addr_x in the same cycle, rd_data_x <= wr_data rather than the old contents.
  - Both ports may bypass simultaneously.
- Both read ports addressing the same register is legal; both return identical data.
- FSM states:
  - IDLE: clr_req=1 -> CLEAR, clear index <= 0, busy <= 1.
  - CLEAR: each cycle reg[index] <= 0 and index <= index+1.
    - When the register at index NUM_REGS-1 is written -> IDLE, busy <= 0.
    - Total is exactly NUM_REGS cycles with busy=1.
    - The index wraps to 0 on exit.
- Simultaneous events:
  - clr_req and wr_en in the same IDLE cycle: clear wins, the write is discarded, wr_drop=1 next cycle.
  - wr_en=1 while in CLEAR: write discarded, wr_drop=1 next cycle, no register change.
  - clr_req while in CLEAR: ignored; the sequence is not restarted.
- Reads during CLEAR return current contents.
  - A register already cleared reads 0; one not yet cleared reads its old value.
  - No bypass from the clear engine.
- wr_drop is 0 in every cycle not listed above.
- All arithmetic is unsigned. Index width is ADDR_W; there is no overflow beyond the wrap.

Decomposition:
- Shared package cr16_pkg holds:
  - constants DATA_W=16, NUM_REGS=16, ADDR_W=4;
  - FSM state encoding RF_IDLE=1'b0, RF_CLEAR=1'b1;
  - reg_idx_t as ADDR_W-bit index type.
- Natural sub-module: rf_clear_seq, containing the FSM, index counter and busy.
  - Its outputs are clr_we and clr_idx into the storage array.
- Storage and read/bypass logic stay in reg_file_16x16.

Test Plan:
- Reset, then write 16'hA5A5 to r3 and hold rd_addr_a=3 -> the cycle after the write edge, rd_data_a=16'hA5A5 and regs_flat[63:48]=16'hA5A5.
- Same-cycle write 16'h1234 to r7 with rd_addr_a=rd_addr_b=7 (r7 previously 16'h0000) -> both ports read 16'h1234 one cycle later (bypass).
- Fill r0..r15 with 16'h0100+i, then pulse clr_req:
  - busy=1 for exactly 16 cycles;
  - after k clear cycles, r0..r(k-1)=0 and the rest are unchanged;
  - all registers are 0 when busy falls.
- wr_en to r2 with 16'hFFFF during CLEAR, and clr_req+wr_en in the same IDLE cycle -> wr_drop=1 for one cycle in each case, and r2 is not 16'hFFFF.
- Drive reset_n=0 at clear cycle 5 with registers holding nonzero values -> next cycle all registers, rd_data_a, rd_data_b and busy are 0, and the FSM is in IDLE.
- Second clr_req pulse at clear cycle 8 -> busy still drops after the 16th cycle counted from the first pulse.

Source files
------------

// File: rtl/cr16_pkg.sv
// cr16_pkg: shared register-file sizes, clear-FSM state encoding and index/word types
package cr16_pkg;
  localparam int DATA_W = 16;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W = $clog2(NUM_REGS);
  typedef enum logic {RF_IDLE = 1'b0, RF_CLEAR = 1'b1} rf_state_t;
  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/reg_file_16x16_if.sv
// reg_file_16x16_if: register-file bus (write, two reads, flat regs, clear request, busy, wr_drop); master drives, slave is the file
interface reg_file_16x16_if;
  import cr16_pkg::*;
  logic wr_en;
  reg_idx_t wr_addr;
  word_t wr_data;
  reg_idx_t rd_addr_a;
  reg_idx_t rd_addr_b;
  word_t rd_data_a;
  word_t rd_data_b;
  logic [NUM_REGS*DATA_W-1:0] regs_flat;
  logic clr_req;
  logic busy;
  logic wr_drop;
  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, clr_req,
    input rd_data_a, rd_data_b, regs_flat, busy, wr_drop
  );
  modport slave (
    input wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, clr_req,
    output rd_data_a, rd_data_b, regs_flat, busy, wr_drop
  );
endinterface

// File: rtl/rf_clear_seq.sv
// rf_clear_seq: clear FSM (in clk, reset_n, clr_req; out clr_we, clr_idx, busy) zeroing one register per cycle for NUM_REGS cycles
module rf_clear_seq
  import cr16_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     clr_req,
  output logic     clr_we,
  output reg_idx_t clr_idx,
  output logic     busy
);
  rf_state_t state;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= RF_IDLE;
      clr_idx <= '0;
      busy <= 1'b0;
    end else if (state == RF_IDLE) begin
      state <= clr_req ? RF_CLEAR : RF_IDLE;
      clr_idx <= '0;
      busy <= clr_req;
    end else begin
      state <= (clr_idx == reg_idx_t'(NUM_REGS-1)) ? RF_IDLE : RF_CLEAR;
      clr_idx <= clr_idx + reg_idx_t'(1);
      busy <= clr_idx != reg_idx_t'(NUM_REGS-1);
    end
  end
  assign clr_we = busy;
endmodule

// File: rtl/reg_file_16x16.sv
// reg_file_16x16: 16x16 register file (in clk, reset_n; bus slave: write, 2 bypassed registered reads, flat regs, clear engine, wr_drop)
module reg_file_16x16
  import cr16_pkg::*;
(
  input logic clk,
  input logic reset_n,
  reg_file_16x16_if.slave bus
);
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic clr_we;
  reg_idx_t clr_idx;
  logic busy;
  logic wr_ok;
  rf_clear_seq u_clr (
    .clk(clk),
    .reset_n(reset_n),
    .clr_req(bus.clr_req),
    .clr_we(clr_we),
    .clr_idx(clr_idx),
    .busy(busy)
  );
  assign wr_ok = bus.wr_en && !busy && !bus.clr_req;
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++)
      regs[i] <= (!reset_n || (clr_we && clr_idx == reg_idx_t'(i))) ? '0 :
                 (wr_ok && bus.wr_addr == reg_idx_t'(i)) ? bus.wr_data : regs[i];
    bus.rd_data_a <= !reset_n ? '0 : (wr_ok && bus.wr_addr == bus.rd_addr_a) ? bus.wr_data : regs[bus.rd_addr_a];
    bus.rd_data_b <= !reset_n ? '0 : (wr_ok && bus.wr_addr == bus.rd_addr_b) ? bus.wr_data : regs[bus.rd_addr_b];
    bus.wr_drop <= reset_n && bus.wr_en && (busy || bus.clr_req);
  end
  assign bus.regs_flat = regs;
  assign bus.busy = busy;
endmodule

// File: tb/tb_reg_file_16x16.sv
// tb_reg_file_16x16: scoreboard bench for reg_file_16x16 with directed steps and a behavioural reference model
module tb_reg_file_16x16;
  import cr16_pkg::*;
  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic busy;
    logic drop;
    logic [255:0] flat;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int busy_cnt;
  logic [15:0] m [16];
  logic m_busy = 1'b0;
  logic [3:0] m_idx = '0;
  exp_t q [$];
  reg_file_16x16_if bus ();
  reg_file_16x16 dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    exp_t e;
    logic wr_ok;
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) m[i] = '0;
      m_busy = 1'b0;
      m_idx = '0;
      e = '0;
    end else begin
      wr_ok = bus.wr_en && !m_busy && !bus.clr_req;
      e.a = (wr_ok && bus.wr_addr == bus.rd_addr_a) ? bus.wr_data : m[bus.rd_addr_a];
      e.b = (wr_ok && bus.wr_addr == bus.rd_addr_b) ? bus.wr_data : m[bus.rd_addr_b];
      e.drop = bus.wr_en && (m_busy || bus.clr_req);
      if (m_busy) begin
        m[m_idx] = '0;
        if (m_idx == 4'd15) m_busy = 1'b0;
        m_idx = m_idx + 4'd1;
      end else if (bus.clr_req) begin
        m_busy = 1'b1;
        m_idx = '0;
      end else if (wr_ok) m[bus.wr_addr] = bus.wr_data;
      e.busy = m_busy;
    end
    for (int i = 0; i < 16; i++) e.flat[i*16 +: 16] = m[i];
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("rd_data_a", 256'(bus.rd_data_a), 256'(e.a));
    chk("rd_data_b", 256'(bus.rd_data_b), 256'(e.b));
    chk("busy", 256'(bus.busy), 256'(e.busy));
    chk("wr_drop", 256'(bus.wr_drop), 256'(e.drop));
    chk("regs_flat", bus.regs_flat, e.flat);
  endtask
  task automatic drive(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic [3:0] ra, input logic [3:0] rb, input logic clr);
    bus.wr_en = we;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    bus.rd_addr_a = ra;
    bus.rd_addr_b = rb;
    bus.clr_req = clr;
  endtask
  task automatic fill();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'(i), 16'h0100 + 16'(i), 4'(i), 4'(15 - i), 1'b0);
      tick();
    end
  endtask
  initial begin
    drive(1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0);
    #1;
    tick();
    tick();
    chk("reset_flat", bus.regs_flat, 256'h0);
    reset_n = 1'b1;
    drive(1'b1, 4'd3, 16'hA5A5, 4'd3, 4'd0, 1'b0);
    tick();
    chk("r3_rd_a", 256'(bus.rd_data_a), 256'h A5A5);
    chk("r3_flat", 256'(bus.regs_flat[63:48]), 256'hA5A5);
    drive(1'b1, 4'd7, 16'h1234, 4'd7, 4'd7, 1'b0);
    tick();
    chk("bypass_a", 256'(bus.rd_data_a), 256'h1234);
    chk("bypass_b", 256'(bus.rd_data_b), 256'h1234);
    fill();
    drive(1'b0, 4'd0, 16'h0, 4'd15, 4'd1, 1'b1);
    tick();
    busy_cnt = bus.busy ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      drive(i == 3, 4'd2, 16'hFFFF, 4'(i), 4'(i + 1), i == 7);
      tick();
      if (i == 3) chk("drop_in_clear", 256'(bus.wr_drop), 256'h1);
      if (bus.busy) busy_cnt++;
    end
    chk("busy_cycles", 256'(busy_cnt), 256'd16);
    chk("all_cleared", bus.regs_flat, 256'h0);
    fill();
    drive(1'b1, 4'd2, 16'hFFFF, 4'd2, 4'd2, 1'b1);
    tick();
    chk("drop_clr_wr", 256'(bus.wr_drop), 256'h1);
    drive(1'b0, 4'd0, 16'h0, 4'd2, 4'd5, 1'b0);
    tick();
    chk("drop_one_cycle", 256'(bus.wr_drop), 256'h0);
    for (int i = 0; i < 16; i++) tick();
    chk("r2_not_ffff", 256'(bus.regs_flat[47:32] !== 16'hFFFF), 256'h1);
    fill();
    drive(1'b0, 4'd0, 16'h0, 4'd9, 4'd12, 1'b1);
    tick();
    drive(1'b0, 4'd0, 16'h0, 4'd9, 4'd12, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    reset_n = 1'b0;
    tick();
    chk("rst_mid_flat", bus.regs_flat, 256'h0);
    chk("rst_mid_busy", 256'(bus.busy), 256'h0);
    reset_n = 1'b1;
    drive(1'b1, 4'd4, 16'hBEEF, 4'd4, 4'd0, 1'b0);
    tick();
    chk("idle_after_rst", 256'(bus.regs_flat[79:64]), 256'hBEEF);
    drive(1'b0, 4'd0, 16'h0, 4'd4, 4'd4, 1'b0);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
